// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } fetch_state_e;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Read port between the prefetch buffer (master) and memory controller port 1 (slave).
interface inst_prefetch_buffer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;

    modport master (
        output mem_req, mem_addr,
        input  i_mem_gnt, i_mem_valid, i_mem_data
    );

    modport slave (
        input  mem_req, mem_addr,
        output i_mem_gnt, i_mem_valid, i_mem_data
    );
endinterface

// File: rtl/inst_prefetch_buffer_fifo.sv
// DEPTH-entry {pc, inst} queue with flush and first-word fall-through head.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           head,
    output logic                   head_vld,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Flush wins over both ends in the same cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head     = mem_q[rd_ptr_q];
    assign head_vld = (count_q != '0);
    assign count    = count_q;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue: sequential word fetch ahead of fetch, flush/redirect on taken branch.
// Define PREFETCH_STATS_EN to add saturating flush_cnt / discard_cnt outputs.
module inst_prefetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_b_taken,
    input  logic [31:0]            i_b_pc,
    input  logic                   i_ready,
    output logic                   valid,
    output logic [31:0]            pc,
    output logic [31:0]            inst,
    inst_prefetch_buffer_if.master mem
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]            flush_cnt,
    output logic [15:0]            discard_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW:0]   count;
    logic          push, pop, head_vld, outstanding;
    logic          credit, credit_after_push;
    logic [PW+1:0] used, after_push;
    fetch_entry_t  head;

    assign pop         = head_vld && i_ready;
    assign outstanding = (state_q == ST_WAIT) || (state_q == ST_DISCARD);
    // Reserving a slot for the in-flight word means a response can always be pushed.
    assign used              = (PW+2)'(count) + (PW+2)'(outstanding);
    assign credit            = used < (PW+2)'(DEPTH);
    assign after_push        = (PW+2)'(count) + (PW+2)'(1) - (PW+2)'(pop);
    assign credit_after_push = after_push < (PW+2)'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_b_taken || credit) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (mem.i_mem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + WORD_BYTES;
                    state_d    = i_b_taken ? ST_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.i_mem_valid) begin
                    push    = !i_b_taken;
                    state_d = (i_b_taken || credit_after_push) ? ST_REQ : ST_IDLE;
                end else if (i_b_taken) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem.i_mem_valid) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_b_taken) fetch_pc_d = i_b_pc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (push),
        .pop      (pop),
        .flush    (i_b_taken),
        .wdata    ('{pc: req_pc_q, inst: mem.i_mem_data}),
        .head     (head),
        .head_vld (head_vld),
        .count    (count)
    );

    assign valid        = head_vld;
    assign pc           = head_vld ? head.pc : 32'd0;
    assign inst         = head_vld ? head.inst : INST_NOP;
    assign mem.mem_req  = (state_q == ST_REQ);
    assign mem.mem_addr = fetch_pc_q;

`ifdef PREFETCH_STATS_EN
    logic [15:0] flush_cnt_q, flush_cnt_d, discard_cnt_q, discard_cnt_d;
    logic        drop;

    // A response is lost either while discarding or when it lands with a branch.
    assign drop = mem.i_mem_valid &&
                  ((state_q == ST_DISCARD) || ((state_q == ST_WAIT) && i_b_taken));

    always_comb begin
        flush_cnt_d   = flush_cnt_q;
        discard_cnt_d = discard_cnt_q;
        if (i_b_taken && (flush_cnt_q != 16'hFFFF))  flush_cnt_d   = flush_cnt_q + 16'd1;
        if (drop && (discard_cnt_q != 16'hFFFF))     discard_cnt_d = discard_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            flush_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            flush_cnt_q   <= flush_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign flush_cnt   = flush_cnt_q;
    assign discard_cnt = discard_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Randomized bench for inst_prefetch_buffer: memory responder + expected-stream scoreboard.
module tb_inst_prefetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst, i_b_taken, i_ready;
    logic [31:0] i_b_pc;
    logic        valid;
    logic [31:0] pc, inst;
`ifdef PREFETCH_STATS_EN
    logic [15:0] flush_cnt, discard_cnt;
`endif

    inst_prefetch_buffer_if mem_if();

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_b_taken   (i_b_taken),
        .i_b_pc      (i_b_pc),
        .i_ready     (i_ready),
        .valid       (valid),
        .pc          (pc),
        .inst        (inst),
        .mem         (mem_if.master)
`ifdef PREFETCH_STATS_EN
        ,
        .flush_cnt   (flush_cnt),
        .discard_cnt (discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          vis;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0, bad = 0, cyc = 0, rel_cyc = 0, first_cyc = 0, gnt_cnt = 0;
    bit          mon_en = 0, first_seen = 0, stray = 0, fired = 0;
    int          gnt_pct = 100, rdy_pct = 100, br_pct = 0, lat_min = 1, lat_max = 1;
    int          force_mode = 0, lat_left = 0;
    logic [31:0] force_addr = 0, force_tgt = 0;
    bit          out_busy = 0, out_live = 0;
    logic [31:0] out_addr = 0, exp_addr = 0;
    int          flush_model = 0, discard_model = 0;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Monitor: the head must match the oldest expected word that has had time to land.
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            bit vis;
            vis = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
            chk("valid", 32'(valid), 32'(vis));
            if (valid && vis) begin
                chk("head_pc", pc, exp_q[0].pc);
                chk("head_inst", inst, exp_q[0].inst);
                if (!first_seen) begin
                    first_seen = 1;
                    first_cyc  = cyc;
                end
            end
            if (!valid) chk("nop_when_empty", inst, NOP);
            if (i_b_taken)                    exp_q.delete();
            else if (valid && i_ready && vis) exp_q.delete(0);
        end
    end

    // One cycle of stimulus: memory responder, branch injection, and expectation update.
    task automatic step();
        bit          g, r, b, rdy;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        g   = 0;
        r   = 0;
        tgt = $urandom & 32'h0000_3FFC;
        if (out_busy) begin
            if (lat_left > 0) lat_left--;
            if (lat_left == 0) r = 1;
            chk("no_req_while_outstanding", 32'(mem_if.mem_req), 32'd0);
        end else if (mem_if.mem_req === 1'b1) begin
            g = ($urandom_range(0, 99) < gnt_pct);
        end
        b   = ($urandom_range(0, 99) < br_pct);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        if (force_mode == 1 && out_busy && !r && out_addr == force_addr) begin
            b = 1; tgt = force_tgt; fired = 1; force_mode = 0;
        end else if (force_mode == 2 && r && exp_q.size() >= 2) begin
            b = 1; tgt = force_tgt; rdy = 1; fired = 1; force_mode = 0;
        end
        if (g) begin
            gnt_cnt++;
            chk("grant_addr", mem_if.mem_addr, exp_addr);
            chk("credit_below_depth", 32'(exp_q.size() < DEPTH), 32'd1);
        end
        mem_if.i_mem_gnt   = g;
        mem_if.i_mem_valid = r || (stray && !out_busy);
        mem_if.i_mem_data  = r ? memfn(out_addr) : $urandom;
        i_b_taken          = b;
        i_b_pc             = tgt;
        i_ready            = rdy;
        if (b) flush_model++;
        if (r) begin
            if (b || !out_live) discard_model++;
            else exp_q.push_back('{pc: out_addr, inst: memfn(out_addr), vis: cyc + 1});
            out_busy = 0;
        end
        if (g) begin
            out_busy = 1;
            out_live = !b;
            out_addr = mem_if.mem_addr;
            lat_left = $urandom_range(lat_min, lat_max);
        end
        if (b) begin
            out_live = 0;
            exp_addr = tgt;
        end else if (g) begin
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        i_rst = 1; i_b_taken = 0; i_b_pc = 0; i_ready = 0;
        mem_if.i_mem_gnt = 0; mem_if.i_mem_valid = 0; mem_if.i_mem_data = 0;
        exp_q.delete();
        out_busy = 0; out_live = 0; exp_addr = RESET_PC;
        flush_model = 0; discard_model = 0; first_seen = 0; force_mode = 0; fired = 0;
        repeat (2) begin @(negedge clk); cyc++; end
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst_mem_addr", mem_if.mem_addr, RESET_PC);
        i_rst = 0;
        rel_cyc = cyc;
        mon_en = 1;
    endtask

    initial begin
        bit found;

        // Straight-line streaming, 1-cycle memory.
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1; br_pct = 0;
        do_reset();
        repeat (20) step();
        chk("first_valid_seen", 32'(first_seen), 32'd1);
        chk("first_valid_latency", 32'(first_cyc - rel_cyc), 32'd3);

        // Stalled fetch: exactly DEPTH words fetched, then drain and resume.
        rdy_pct = 0;
        do_reset();
        gnt_cnt = 0;
        repeat (20) step();
        chk("grants_while_stalled", 32'(gnt_cnt), 32'(DEPTH));
        chk("req_low_when_full", 32'(mem_if.mem_req), 32'd0);
        rdy_pct = 100;
        repeat (20) step();

        // Branch while waiting on 0x8.
        lat_min = 2; lat_max = 2;
        do_reset();
        force_mode = 1; force_addr = 32'h8; force_tgt = 32'h100;
        repeat (30) step();
        chk("branch_in_wait_fired", 32'(fired), 32'd1);

        // Branch landing with a response while two entries are queued.
        rdy_pct = 30; lat_min = 1; lat_max = 2;
        do_reset();
        force_mode = 2; force_tgt = 32'h100;
        repeat (60) step();
        chk("branch_with_resp_fired", 32'(fired), 32'd1);

        // Concurrent push/pop across pointer wrap, then random branches.
        rdy_pct = 60; gnt_pct = 70; lat_min = 1; lat_max = 3;
        repeat (150) step();
        br_pct = 5;
        repeat (300) step();
        br_pct = 0;
        repeat (10) step();
`ifdef PREFETCH_STATS_EN
        chk("flush_cnt", 32'(flush_cnt), 32'(flush_model));
        chk("discard_cnt", 32'(discard_cnt), 32'(discard_model));
`endif

        // Reset while waiting at fetch_pc=0x40, then a stray response.
        gnt_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (out_busy && out_addr == 32'h3C) found = 1;
        end
        chk("reached_addr_0x3c", 32'(found), 32'd1);
        step();
        #3;
        i_rst = 1;
        #1;
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        do_reset();
        stray = 1;
        step();
        stray = 0;
        repeat (30) step();
`ifdef PREFETCH_STATS_EN
        chk("flush_cnt_after_rst", 32'(flush_cnt), 32'(flush_model));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
